// File: rtl/serial2parallel_sync.sv
`default_nettype none
// =============================================================================
// Module  : serial2parallel_sync
// Purpose : sync-word framed serial-to-parallel deserializer with flywheel
//           lock; define SER2PAR_MISS_CNT_EN to add the sync_miss_total counter.
// Rev     : 1.0
// =============================================================================
module serial2parallel_sync #(
  parameter int                  WIDTH      = 2,
  parameter int                  SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'hB8,
  parameter int                  FRAME_SYMS = 16,
  parameter int                  MISS_LIMIT = 2
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             serial_sig,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] parallel_sig,
  output logic             parallel_valid,
  output logic             frame_start,
  output logic             locked
`ifdef SER2PAR_MISS_CNT_EN
  ,
  output logic [15:0]      sync_miss_total
`endif
);

  // One bit counter serves both the symbol slot (LOCKED) and the sync slot (CHECK).
  localparam int c_bit_range = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
  localparam int c_bit_w     = $clog2(c_bit_range);
  localparam int c_sym_w     = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
  localparam int c_miss_w    = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
  localparam logic [c_bit_w-1:0] c_width_last = c_bit_w'(WIDTH - 1);
  localparam logic [c_bit_w-1:0] c_sync_last  = c_bit_w'(SYNC_LEN - 1);
  localparam logic [c_sym_w-1:0] c_sym_last   = c_sym_w'(FRAME_SYMS - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_CHECK  = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [SYNC_LEN-1:0] sync_sr_q,  sync_sr_d;
  logic [WIDTH-1:0]    asm_q,      asm_d;
  logic [c_bit_w-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [c_sym_w-1:0]  sym_cnt_q,  sym_cnt_d;
  logic [c_miss_w-1:0] miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0]    par_q,      par_d;
  logic                pvalid_q,   pvalid_d;
  logic                fstart_q,   fstart_d;

  logic [SYNC_LEN-1:0] sr_shift;
  logic [WIDTH-1:0]    asm_shift;
  logic                sync_hit;

  assign sr_shift  = {sync_sr_q[SYNC_LEN-2:0], serial_sig};
  assign asm_shift = {asm_q[WIDTH-2:0], serial_sig};
  assign sync_hit  = (sr_shift == SYNC_WORD);

  always_comb begin
    state_d    = state_q;
    sync_sr_d  = sync_sr_q;
    asm_d      = asm_q;
    bit_cnt_d  = bit_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    miss_cnt_d = miss_cnt_q;
    par_d      = par_q;
    pvalid_d   = 1'b0;
    fstart_d   = 1'b0;
    if (serial_valid) begin
      case (state_q)
        ST_HUNT: begin
          sync_sr_d = sr_shift;
          if (sync_hit) begin
            state_d    = ST_LOCKED;
            bit_cnt_d  = '0;
            sym_cnt_d  = '0;
            miss_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          asm_d = asm_shift;
          if (bit_cnt_q == c_width_last) begin
            bit_cnt_d = '0;
            par_d     = asm_shift;
            pvalid_d  = 1'b1;
            fstart_d  = (sym_cnt_q == '0);
            if (sym_cnt_q == c_sym_last) begin
              sym_cnt_d = '0;
              sync_sr_d = '0;
              state_d   = ST_CHECK;
            end else begin
              sym_cnt_d = sym_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          sync_sr_d = sr_shift;
          if (bit_cnt_q == c_sync_last) begin
            bit_cnt_d = '0;
            if (sync_hit) begin
              miss_cnt_d = '0;
              state_d    = ST_LOCKED;
            end else if ((int'(miss_cnt_q) + 1) < MISS_LIMIT) begin
              miss_cnt_d = miss_cnt_q + 1'b1;
              state_d    = ST_LOCKED;
            end else begin
              // Dropping lock keeps sync_sr so an immediately following sync re-locks.
              miss_cnt_d = '0;
              state_d    = ST_HUNT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q    <= ST_HUNT;
      sync_sr_q  <= '0;
      asm_q      <= '0;
      bit_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      miss_cnt_q <= '0;
      par_q      <= '0;
      pvalid_q   <= 1'b0;
      fstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_sr_q  <= sync_sr_d;
      asm_q      <= asm_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      par_q      <= par_d;
      pvalid_q   <= pvalid_d;
      fstart_q   <= fstart_d;
    end
  end

  assign parallel_sig   = par_q;
  assign parallel_valid = pvalid_q;
  assign frame_start    = fstart_q;
  assign locked         = (state_q != ST_HUNT);

`ifdef SER2PAR_MISS_CNT_EN
  logic        miss_event;
  logic [15:0] miss_total_q, miss_total_d;

  assign miss_event = serial_valid && (state_q == ST_CHECK) &&
                      (bit_cnt_q == c_sync_last) && !sync_hit;

  always_comb begin
    miss_total_d = miss_total_q;
    if (miss_event && (miss_total_q != 16'hFFFF)) miss_total_d = miss_total_q + 16'd1;
  end

  always_ff @(posedge clk_sig) begin
    if (reset_sig) miss_total_q <= '0;
    else           miss_total_q <= miss_total_d;
  end

  assign sync_miss_total = miss_total_q;
`endif

endmodule
`default_nettype wire

// File: doc/serial2parallel_sync.md
Name: serial2parallel_sync

Overview:
- Receive-side deserializer; sits directly downstream of the transmit-side parallel-to-serial stage, across the channel model.
- Hunts a fixed sync word in the serial bit stream and locks frame alignment.
- Regroups each following payload bit-group into a WIDTH-bit symbol for the decoder.
- Flywheels through occasional sync misses; drops lock after MISS_LIMIT consecutive misses.

Parameters:
WIDTH, 2, bits per parallel symbol (encoder output width); >=2
SYNC_LEN, 8, sync word length in bits; >=2
SYNC_WORD, 8'hB8, sync pattern; bit SYNC_LEN-1 is received first
FRAME_SYMS, 16, payload symbols per frame after each sync word; >=1
MISS_LIMIT, 2, consecutive sync misses that drop lock; >=1

Ports:
clk_sig  input  1  system clock, all logic on rising edge
reset_sig  input  1  synchronous reset, active-high
serial_sig  input  1  received serial bit
serial_valid  input  1  qualifies serial_sig; nothing advances while low
parallel_sig  output  WIDTH  assembled symbol; first received bit in [WIDTH-1]
parallel_valid  output  1  one-cycle strobe, parallel_sig valid
frame_start  output  1  high together with parallel_valid on symbol 0 of each frame
locked  output  1  high in states LOCKED and CHECK

Behaviour:
- Reset values when reset_sig=1 at a clock edge:
  - parallel_sig=0, parallel_valid=0, frame_start=0, locked=0.
  - State=HUNT; sync shift register, bit counter, symbol counter and miss counter all cleared.
  - Reset mid-frame discards any partial symbol.
- Bit ingest:
  - A bit is consumed only on an edge with serial_valid=1.
  - sync_sr <= {sync_sr[SYNC_LEN-2:0], serial_sig}; the comparison uses this shifted-in value, including the current bit.
- HUNT:
  - Shift every valid bit.
  - On match with SYNC_WORD: go to LOCKED, clear bit and symbol counters, clear miss counter.
  - The next valid bit is payload bit 0.
- LOCKED:
  - Shift valid bits into a WIDTH-bit assembly register, MSB first.
  - On the WIDTH-th bit, the next edge presents parallel_sig=assembled symbol with parallel_valid=1 for exactly one cycle. Latency is 1 clock from the edge sampling the last bit.
  - frame_start=1 on the strobe of symbol index 0.
  - After symbol FRAME_SYMS-1 is sampled: clear sync_sr, go to CHECK.
- CHECK:
  - Collect exactly SYNC_LEN valid bits into sync_sr; no parallel output.
  - On the SYNC_LEN-th bit, match: miss counter=0, go to LOCKED.
  - Mismatch with miss+1 < MISS_LIMIT: miss counter+1, go to LOCKED anyway (flywheel), treating the received bits as the sync slot.
  - Mismatch with miss+1 == MISS_LIMIT: go to HUNT, locked falls on the same edge, miss counter=0.
  - On HUNT re-entry sync_sr keeps the just-received bits, so a sync word immediately present can re-lock.
- Counter widths: clog2 of the respective range, minimum 1 bit. No wrap beyond FRAME_SYMS-1 or SYNC_LEN-1.
- Gaps: serial_valid gaps of any length are transparent; state, counters and the partial symbol hold.
- parallel_valid never asserts in HUNT or CHECK. The strobe is never back-to-back unless serial_valid was continuously high and WIDTH=... impossible for WIDTH>=2, so the minimum spacing is WIDTH cycles.

Optional Feature:
- Macro: SER2PAR_MISS_CNT_EN.
- Defined:
  - Adds output port sync_miss_total, 16 bits, reset 0.
  - Increments by 1 on every CHECK mismatch, including the one that drops lock.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 20 random bits not containing 8'hB8 -> locked=0, parallel_valid never 1.
- Defaults; send B8 (10111000), then payload 2'b10,2'b01 ×8 -> locked rises after the 8th sync bit; 16 strobes alternating 2'b10/2'b01; frame_start only on the first; then enters CHECK.
- Second frame with correct B8 then payload 2'b11 ×16 -> 16 strobes of 2'b11, frame_start on the first, locked held.
- After lock, corrupt one sync (send 8'hB9), next sync correct -> flywheel: frame still decoded, locked stays 1; with SER2PAR_MISS_CNT_EN, sync_miss_total=1.
- Two consecutive corrupted syncs (8'h00, 8'h00) -> locked drops on the edge of the 8th bit of the second bad sync; no further strobes until B8 is seen again.
- Valid serial_valid pattern 1,0,0,1 within a symbol, plus reset_sig pulse mid-symbol in a second run -> a gap-interleaved symbol is assembled correctly; after reset all outputs are 0 and the partial symbol is never emitted.
